// File: rtl/segre_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// segre_hazard_ctrl
//   EX-stage hazard controller. A shadow pipe records the producers that are
//   still in flight. From it, and from the instruction in ID, the block works
//   out the bypass selects, the load-use and mul-use stalls, the NOP injection
//   after a taken branch, and the freeze while MEM is stalled.
//
//   Bypass select encoding (bypass_ex_sel_e):
//     0 NO_BYPASS, 1 MEM_BYPASS, 2 WB_BYPASS, 3 MUL_M5_BYPASS
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   id_*_i                decoded fields of the instruction held in ID
//   tkbr_i                taken branch/jump resolved in EX
//   mem_stall_i           MEM cannot advance; freezes the whole controller
//   mux_sel_a_o/_b_o      bypass selects for ALU/branch operands a and b
//   mux_sel_load_o        bypass select for store data
//   block_if_id_o         hold IF and ID
//   block_ex_o            hold the ID/EX register
//   inject_nops_o         load a bubble into ID/EX
//   flush_id_o            discard the instruction in ID
//   stall_cnt_o           saturating count of hazard-stall cycles
// -----------------------------------------------------------------------------
module segre_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_addr_i,
  input  logic              id_rs1_used_i,
  input  logic [REG_AW-1:0] id_rs2_addr_i,
  input  logic              id_rs2_used_i,
  input  logic [REG_AW-1:0] id_rd_addr_i,
  input  logic              id_rf_we_i,
  input  logic              id_is_load_i,
  input  logic              id_is_store_i,
  input  logic              id_is_mul_i,
  input  logic              tkbr_i,
  input  logic              mem_stall_i,
  output logic [1:0]        mux_sel_a_o,
  output logic [1:0]        mux_sel_b_o,
  output logic [1:0]        mux_sel_load_o,
  output logic              block_if_id_o,
  output logic              block_ex_o,
  output logic              inject_nops_o,
  output logic              flush_id_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef enum logic [1:0] {
    NO_BYPASS     = 2'd0,
    MEM_BYPASS    = 2'd1,
    WB_BYPASS     = 2'd2,
    MUL_M5_BYPASS = 2'd3
  } bypass_ex_sel_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              is_load;
    logic              is_mul;
  } shadow_t;

  typedef struct packed {
    logic           stall;
    bypass_ex_sel_e sel;
  } sel_res_t;

  // Entry k holds the instruction issued k cycles ago.
  shadow_t [6:1]    r_pipe;
  state_e           r_state;
  logic [CNT_W-1:0] r_stall_cnt;

  state_e   w_state_nxt;
  sel_res_t w_res_a;
  sel_res_t w_res_b;
  sel_res_t w_res_st;
  logic     w_hazard_stall;
  logic     w_issue;
  logic     w_cnt_inc;

  // Scan from oldest to youngest so the youngest matching producer wins.
  // store_data marks the store-data path, which has no M5 bypass port.
  function automatic sel_res_t resolve(input shadow_t [6:1]    pipe,
                                       input logic [REG_AW-1:0] src,
                                       input logic              used,
                                       input logic              store_data);
    sel_res_t res;
    res.stall = 1'b0;
    res.sel   = NO_BYPASS;
    for (int k = 6; k >= 1; k--) begin
      if (pipe[k[2:0]].valid && pipe[k[2:0]].we && (pipe[k[2:0]].rd == src) &&
          (src != '0) && used) begin
        res.stall = 1'b0;
        res.sel   = NO_BYPASS;
        if (pipe[k[2:0]].is_mul) begin
          // Multiplier result exists only from M5 onwards.
          if (k <= 3)      res.stall = 1'b1;
          else if (k == 4) begin
            if (store_data) res.stall = 1'b1;
            else            res.sel   = MUL_M5_BYPASS;
          end
          else if (k == 5) res.sel = WB_BYPASS;
        end else begin
          if (k == 1) begin
            if (pipe[k[2:0]].is_load) res.stall = 1'b1;
            else                      res.sel   = MEM_BYPASS;
          end
          else if (k == 2) res.sel = WB_BYPASS;
        end
      end
    end
    return res;
  endfunction

  always_comb begin
    w_res_a  = resolve(r_pipe, id_rs1_addr_i, id_rs1_used_i, 1'b0);
    w_res_b  = resolve(r_pipe, id_rs2_addr_i, id_rs2_used_i & ~id_is_store_i, 1'b0);
    w_res_st = resolve(r_pipe, id_rs2_addr_i, id_rs2_used_i & id_is_store_i, 1'b1);
  end

  assign w_hazard_stall = id_valid_i & (w_res_a.stall | w_res_b.stall | w_res_st.stall);

  // Selects are meaningless while stalling or in reset; park them on NO_BYPASS.
  always_comb begin
    mux_sel_a_o    = NO_BYPASS;
    mux_sel_b_o    = NO_BYPASS;
    mux_sel_load_o = NO_BYPASS;
    if (!rst_i && !w_hazard_stall) begin
      mux_sel_a_o    = w_res_a.sel;
      mux_sel_b_o    = w_res_b.sel;
      mux_sel_load_o = w_res_st.sel;
    end
  end

  // Next state and control outputs; priority freeze > flush > stall > issue.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // one unassigned, which would infer a latch.
    w_state_nxt   = r_state;
    block_if_id_o = 1'b0;
    block_ex_o    = 1'b0;
    inject_nops_o = 1'b0;
    flush_id_o    = 1'b0;
    w_issue       = 1'b0;
    w_cnt_inc     = 1'b0;
    if (rst_i) begin
      inject_nops_o = 1'b1;
      w_state_nxt   = ST_RUN;
    end else if (mem_stall_i) begin
      block_if_id_o = 1'b1;
      block_ex_o    = 1'b1;
    end else if ((r_state == ST_FLUSH) || tkbr_i) begin
      // tkbr_i is ignored in FLUSH: the flush always lasts exactly two cycles.
      flush_id_o    = 1'b1;
      inject_nops_o = 1'b1;
      w_state_nxt   = (r_state == ST_RUN) ? ST_FLUSH : ST_RUN;
    end else if (w_hazard_stall) begin
      block_if_id_o = 1'b1;
      inject_nops_o = 1'b1;
      w_cnt_inc     = 1'b1;
    end else begin
      inject_nops_o = ~id_valid_i;
      w_issue       = id_valid_i;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst_i) begin
      r_pipe      <= '0;
      r_state     <= ST_RUN;
      r_stall_cnt <= '0;
    end else if (!mem_stall_i) begin
      r_pipe[6:2] <= r_pipe[5:1];
      if (w_issue) begin
        r_pipe[1] <= '{valid: 1'b1, rd: id_rd_addr_i, we: id_rf_we_i,
                       is_load: id_is_load_i, is_mul: id_is_mul_i};
      end else begin
        r_pipe[1] <= '0;
      end
      r_state <= w_state_nxt;
      if (w_cnt_inc && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_segre_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_segre_hazard_ctrl
//   Directed-vector bench for segre_hazard_ctrl. Inputs change 1 ns after the
//   rising edge; outputs are compared on the falling edge.
// -----------------------------------------------------------------------------
module tb_segre_hazard_ctrl;

  localparam logic [1:0] NO  = 2'd0;
  localparam logic [1:0] MEM = 2'd1;
  localparam logic [1:0] WB  = 2'd2;
  localparam logic [1:0] M5  = 2'd3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        id_valid_i;
  logic [4:0]  id_rs1_addr_i;
  logic        id_rs1_used_i;
  logic [4:0]  id_rs2_addr_i;
  logic        id_rs2_used_i;
  logic [4:0]  id_rd_addr_i;
  logic        id_rf_we_i;
  logic        id_is_load_i;
  logic        id_is_store_i;
  logic        id_is_mul_i;
  logic        tkbr_i;
  logic        mem_stall_i;
  logic [1:0]  mux_sel_a_o;
  logic [1:0]  mux_sel_b_o;
  logic [1:0]  mux_sel_load_o;
  logic        block_if_id_o;
  logic        block_ex_o;
  logic        inject_nops_o;
  logic        flush_id_o;
  logic [15:0] stall_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  segre_hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .id_valid_i     (id_valid_i),
    .id_rs1_addr_i  (id_rs1_addr_i),
    .id_rs1_used_i  (id_rs1_used_i),
    .id_rs2_addr_i  (id_rs2_addr_i),
    .id_rs2_used_i  (id_rs2_used_i),
    .id_rd_addr_i   (id_rd_addr_i),
    .id_rf_we_i     (id_rf_we_i),
    .id_is_load_i   (id_is_load_i),
    .id_is_store_i  (id_is_store_i),
    .id_is_mul_i    (id_is_mul_i),
    .tkbr_i         (tkbr_i),
    .mem_stall_i    (mem_stall_i),
    .mux_sel_a_o    (mux_sel_a_o),
    .mux_sel_b_o    (mux_sel_b_o),
    .mux_sel_load_o (mux_sel_load_o),
    .block_if_id_o  (block_if_id_o),
    .block_ex_o     (block_ex_o),
    .inject_nops_o  (inject_nops_o),
    .flush_id_o     (flush_id_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare the control outputs as a group {block_if_id, block_ex, inject, flush}.
  task automatic check_ctl(input string tag, input logic [3:0] exp);
    check(tag, {28'd0, block_if_id_o, block_ex_o, inject_nops_o, flush_id_o}, {28'd0, exp});
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic u1, input logic [4:0] rs2, input logic u2,
                       input logic we, input logic ld, input logic st, input logic mul);
    id_valid_i    = v;
    id_rd_addr_i  = rd;
    id_rs1_addr_i = rs1;
    id_rs1_used_i = u1;
    id_rs2_addr_i = rs2;
    id_rs2_used_i = u2;
    id_rf_we_i    = we;
    id_is_load_i  = ld;
    id_is_store_i = st;
    id_is_mul_i   = mul;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
  endtask

  task automatic drain();
    idle();
    repeat (7) tick();
  endtask

  initial begin
    rst_i       = 1'b1;
    tkbr_i      = 1'b0;
    mem_stall_i = 1'b0;
    idle();

    // Reset values while rst_i is high (even with a branch requested).
    tkbr_i = 1'b1;
    sample();
    check("rst_sel_a", {30'd0, mux_sel_a_o}, {30'd0, NO});
    check_ctl("rst_ctl", 4'b0010);
    tick();
    tkbr_i = 1'b0;
    rst_i  = 1'b0;
    sample();
    check("rst_cnt", {16'd0, stall_cnt_o}, 32'd0);
    check_ctl("rst_idle_ctl", 4'b0010);

    // add x1 ; add x2,x1,x1 -> MEM bypass on both operands.
    drive(1'b1, 5'd1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    sample();
    check_ctl("add1_issue", 4'b0000);
    tick();
    drive(1'b1, 5'd2, 5'd1, 1'b1, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    sample();
    check("alu_sel_a", {30'd0, mux_sel_a_o}, {30'd0, MEM});
    check("alu_sel_b", {30'd0, mux_sel_b_o}, {30'd0, MEM});
    check_ctl("alu_nostall", 4'b0000);
    tick();
    drain();

    // lw x3 ; add x4,x3,x0 -> one stall cycle then WB bypass.
    drive(1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd4, 5'd3, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    sample();
    check_ctl("lu_stall", 4'b1010);
    tick();
    sample();
    check("lu_sel_a", {30'd0, mux_sel_a_o}, {30'd0, WB});
    check_ctl("lu_go", 4'b0000);
    check("lu_cnt", {16'd0, stall_cnt_o}, 32'd1);
    tick();
    drain();

    // Reset so the mul test starts from a zero counter.
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;

    // mul x5 ; add x6,x5,x0 -> 3 stalls then M5 bypass.
    drive(1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 5'd6, 5'd5, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      sample();
      check($sformatf("mu_stall%0d", i), {31'd0, block_if_id_o}, 32'd1);
      tick();
    end
    sample();
    check("mu_sel_a", {30'd0, mux_sel_a_o}, {30'd0, M5});
    check_ctl("mu_go", 4'b0000);
    check("mu_cnt", {16'd0, stall_cnt_o}, 32'd3);
    tick();
    drain();

    // mul x7 ; sw x7,0(x8) -> 4 stalls then WB on store data.
    drive(1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 5'd0, 5'd8, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      sample();
      check_ctl($sformatf("ms_stall%0d", i), 4'b1010);
      tick();
    end
    sample();
    check("ms_sel_load", {30'd0, mux_sel_load_o}, {30'd0, WB});
    check("ms_sel_b", {30'd0, mux_sel_b_o}, {30'd0, NO});
    check_ctl("ms_go", 4'b0000);
    check("ms_cnt", {16'd0, stall_cnt_o}, 32'd7);
    tick();
    drain();

    // Single-cycle branch pulse; add x9 in ID during it must not enter the pipe.
    drive(1'b1, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tkbr_i = 1'b1;
    sample();
    check_ctl("br_c1", 4'b0011);
    tick();
    tkbr_i = 1'b0;
    sample();
    check_ctl("br_c2", 4'b0011);
    tick();
    drive(1'b1, 5'd11, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    sample();
    check_ctl("br_run", 4'b0000);
    check("br_no_fwd", {30'd0, mux_sel_a_o}, {30'd0, NO});
    tick();

    // Branch held for two cycles: still exactly two flush cycles.
    tkbr_i = 1'b1;
    sample();
    check_ctl("brh_c1", 4'b0011);
    tick();
    sample();
    check_ctl("brh_c2", 4'b0011);
    tick();
    tkbr_i = 1'b0;
    sample();
    check("brh_c3", {31'd0, flush_id_o}, 32'd0);
    tick();
    drain();

    // lw x3 ; add x4,x3 with a 3-cycle freeze at the stall (branch ignored).
    drive(1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd4, 5'd3, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    mem_stall_i = 1'b1;
    tkbr_i      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      check_ctl($sformatf("frz_ctl%0d", i), 4'b1100);
      check($sformatf("frz_cnt%0d", i), {16'd0, stall_cnt_o}, 32'd7);
      tick();
      tkbr_i = 1'b0;
    end
    mem_stall_i = 1'b0;
    sample();
    check_ctl("frz_stall", 4'b1010);
    tick();
    sample();
    check("frz_sel_a", {30'd0, mux_sel_a_o}, {30'd0, WB});
    check("frz_cnt", {16'd0, stall_cnt_o}, 32'd8);
    tick();
    drain();

    // lw x0 ; add x12,x0,x0 -> x0 is never a producer.
    drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd12, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    sample();
    check_ctl("x0_ctl", 4'b0000);
    check("x0_sel_a", {30'd0, mux_sel_a_o}, {30'd0, NO});
    tick();
    drain();

    // Reset asserted during FLUSH -> RUN and counter cleared next cycle.
    tkbr_i = 1'b1;
    tick();
    tkbr_i = 1'b0;
    rst_i  = 1'b1;
    sample();
    check_ctl("rflush_rst", 4'b0010);
    tick();
    rst_i = 1'b0;
    drive(1'b1, 5'd13, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    sample();
    check_ctl("rflush_run", 4'b0000);
    check("rflush_cnt", {16'd0, stall_cnt_o}, 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
